// File: rtl/acc_operand_sequencer_pkg.sv
// Shared types and default constants for the accumulator operand sequencer.
package acc_operand_sequencer_pkg;

    localparam int unsigned N_DEF       = 8;
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_e;

    // FIFO entry is {last, data}
    function automatic int unsigned fifo_entry_w(input int unsigned n);
        return n + 1;
    endfunction

    localparam int unsigned ENTRY_W_DEF = N_DEF + 1;

endpackage

// File: rtl/acc_op_fifo.sv
// Small synchronous FIFO; pointers wrap naturally because DEPTH is a power of 2.
module acc_op_fifo #(
    parameter  int unsigned W     = 9,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/acc_operand_sequencer.sv
// Feeds operand batches to the serial accumulator and captures batch sums.
module acc_operand_sequencer
    import acc_operand_sequencer_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic [N-1:0]     in_data_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             load_input_o,
    output logic [N-1:0]     input_data_o,
    output logic             clear_acc_o,
    input  logic [N-1:0]     acc_sum_i,
    input  logic             acc_done_i,
    output logic [N-1:0]     result_o,
    output logic [CNT_W-1:0] result_count_o,
    output logic             result_valid_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned EW   = fifo_entry_w(N);
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned WD_W = $clog2(TIMEOUT);

    seq_state_e       state_q, state_d;
    logic             first_pending_q, first_pending_d;
    logic             cur_last_q, cur_last_d;
    logic [N-1:0]     input_data_q, input_data_d;
    logic [CNT_W-1:0] batch_cnt_q, batch_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [N-1:0]     result_q, result_d;
    logic [CNT_W-1:0] result_count_q, result_count_d;
    logic             result_valid_q, result_valid_d;
    logic             load_q, load_d;
    logic             clear_q, clear_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             push_c;
    logic             pop_c;
    logic [EW-1:0]    head_c;
    logic             full_c;
    logic             empty_c;
    logic [CW-1:0]    count_c;
    logic [CW-1:0]    count_nxt_c;

    assign push_c     = in_valid_i && !full_c;
    assign in_ready_o = !full_c;

    acc_op_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .din_i   ({in_last_i, in_data_i}),
        .dout_o  (head_c),
        .full_o  (full_c),
        .empty_o (empty_c),
        .count_o (count_c)
    );

    // Next-state, datapath updates and pulse generation
    always_comb begin
        state_d         = state_q;
        first_pending_d = first_pending_q;
        cur_last_d      = cur_last_q;
        input_data_d    = input_data_q;
        batch_cnt_d     = batch_cnt_q;
        wd_d            = wd_q;
        result_d        = result_q;
        result_count_d  = result_count_q;
        result_valid_d  = 1'b0;
        err_d           = err_q;
        pop_c           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    if (first_pending_q) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_ISSUE;
                        pop_c   = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                first_pending_d = 1'b0;
                pop_c           = 1'b1;
                state_d         = ST_ISSUE;
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (acc_done_i) begin
                    batch_cnt_d = batch_cnt_q + CNT_W'(1);
                    if (cur_last_q) begin
                        result_d        = acc_sum_i;
                        result_count_d  = batch_cnt_q + CNT_W'(1);
                        result_valid_d  = 1'b1;
                        batch_cnt_d     = '0;
                        first_pending_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    // Abandon the batch; whatever is queued starts afresh
                    err_d           = 1'b1;
                    first_pending_d = 1'b1;
                    batch_cnt_d     = '0;
                    state_d         = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pop_c) begin
            input_data_d = head_c[N-1:0];
            cur_last_d   = head_c[N];
        end

        clear_d     = (state_d == ST_CLEAR);
        load_d      = (state_d == ST_ISSUE);
        count_nxt_c = count_c + CW'(push_c) - CW'(pop_c);
        busy_d      = (state_d != ST_IDLE) || (count_nxt_c != '0);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            first_pending_q <= 1'b1;
            cur_last_q      <= 1'b0;
            input_data_q    <= '0;
            batch_cnt_q     <= '0;
            wd_q            <= '0;
            result_q        <= '0;
            result_count_q  <= '0;
            result_valid_q  <= 1'b0;
            load_q          <= 1'b0;
            clear_q         <= 1'b0;
            err_q           <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            first_pending_q <= first_pending_d;
            cur_last_q      <= cur_last_d;
            input_data_q    <= input_data_d;
            batch_cnt_q     <= batch_cnt_d;
            wd_q            <= wd_d;
            result_q        <= result_d;
            result_count_q  <= result_count_d;
            result_valid_q  <= result_valid_d;
            load_q          <= load_d;
            clear_q         <= clear_d;
            err_q           <= err_d;
            busy_q          <= busy_d;
        end
    end

    assign load_input_o   = load_q;
    assign input_data_o   = input_data_q;
    assign clear_acc_o    = clear_q;
    assign result_o       = result_q;
    assign result_count_o = result_count_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = busy_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_acc_operand_sequencer.sv
// Randomised and directed checks of the operand sequencer against a batch-level model.
module tb_acc_operand_sequencer;

    localparam int unsigned N       = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             in_ready_o;
    logic             load_input_o;
    logic [N-1:0]     input_data_o;
    logic             clear_acc_o;
    logic [N-1:0]     acc_sum;
    logic             acc_done;
    logic [N-1:0]     result_o;
    logic [CNT_W-1:0] result_count_o;
    logic             result_valid_o;
    logic             busy_o;
    logic             err_o;

    acc_operand_sequencer #(
        .N(N), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .in_last_i      (in_last),
        .in_ready_o     (in_ready_o),
        .load_input_o   (load_input_o),
        .input_data_o   (input_data_o),
        .clear_acc_o    (clear_acc_o),
        .acc_sum_i      (acc_sum),
        .acc_done_i     (acc_done),
        .result_o       (result_o),
        .result_count_o (result_count_o),
        .result_valid_o (result_valid_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Batch-level reference model
    logic [N:0]      word_q[$];
    logic [15:0]     exp_q[$];
    logic [N-1:0]    psum;
    logic [CNT_W-1:0] pcnt;
    int              n_push, n_load, n_clear, n_rv;
    bit              bstart, seen_clear;
    bit              chk_err;
    logic            exp_err;
    int              cyc, last_load_cyc;
    bit              accepted;

    // Behavioural accumulator stub
    bit              pend, hang;
    int              tmr, lat_fix;
    logic [N-1:0]    pdata, stub_sum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        word_q.delete();
        exp_q.delete();
        psum = '0; pcnt = '0;
        n_push = 0; n_load = 0;
        bstart = 1'b1; seen_clear = 1'b0;
        pend = 1'b0; acc_done = 1'b0;
    endtask

    task automatic model_push(input logic [N-1:0] d, input logic l);
        word_q.push_back({l, d});
        n_push++;
        psum = psum + d;
        pcnt = pcnt + CNT_W'(1);
        if (l) begin
            exp_q.push_back({pcnt, psum});
            psum = '0; pcnt = '0;
        end
    endtask

    task automatic monitor();
        logic [N:0]  w;
        logic [15:0] e;
        if (load_input_o) begin
            n_load++;
            last_load_cyc = cyc;
            chk("load_clear_excl", 32'(clear_acc_o), 32'(0));
            chk("load_has_word", 32'(word_q.size() != 0), 32'(1));
            if (word_q.size() != 0) begin
                w = word_q.pop_front();
                chk("input_data", 32'(input_data_o), 32'(w[N-1:0]));
                chk("batch_clear", 32'(seen_clear), 32'(bstart));
                bstart = w[N];
                seen_clear = 1'b0;
            end
        end
        if (clear_acc_o) begin
            n_clear++;
            chk("clear_at_start", 32'(bstart), 32'(1));
            seen_clear = 1'b1;
        end
        chk("in_ready", 32'(in_ready_o), 32'((n_push - n_load) != int'(DEPTH)));
        if (n_push - n_load > 0) chk("busy", 32'(busy_o), 32'(1));
        if (chk_err) chk("err", 32'(err_o), 32'(exp_err));
        if (result_valid_o) begin
            n_rv++;
            chk("result_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("result", 32'(result_o), 32'(e[7:0]));
                chk("result_count", 32'(result_count_o), 32'(e[15:8]));
            end
        end
        if (clear_acc_o) stub_sum = '0;
        if (load_input_o && !hang) begin
            pend  = 1'b1;
            tmr   = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 12));
            pdata = input_data_o;
        end
        acc_done = 1'b0;
        if (pend) begin
            if (tmr == 0) begin
                stub_sum = stub_sum + pdata;
                acc_sum  = stub_sum;
                acc_done = 1'b1;
                pend     = 1'b0;
            end else begin
                tmr--;
            end
        end
    endtask

    task automatic step();
        logic           acc;
        logic [N-1:0]   d;
        logic           l;
        acc = in_valid && in_ready_o && !reset;
        d = in_data;
        l = in_last;
        @(posedge clk);
        #1;
        cyc++;
        accepted = acc;
        if (acc) model_push(d, l);
        monitor();
    endtask

    task automatic push_word(input logic [N-1:0] d, input logic l);
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int i = 0; i < 300; i++) begin
            step();
            if (accepted) break;
        end
        chk("push_accept", 32'(accepted), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (word_q.size() == 0 && exp_q.size() == 0 && !pend) break;
            step();
        end
        chk("drain_done", 32'(word_q.size() + exp_q.size()), 32'(0));
        step();
        chk("idle_busy", 32'(busy_o), 32'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0, r0;
        logic [N-1:0] b_sum;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        acc_done = 1'b0; acc_sum = '0; stub_sum = '0;
        hang = 1'b0; lat_fix = 0; cyc = 0; n_clear = 0; n_rv = 0;
        chk_err = 1'b1; exp_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready_o), 32'(1));
        chk("rst_load", 32'(load_input_o), 32'(0));
        chk("rst_clear", 32'(clear_acc_o), 32'(0));
        chk("rst_rv", 32'(result_valid_o), 32'(0));
        chk("rst_err", 32'(err_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_input_data", 32'(input_data_o), 32'(0));
        chk("rst_result", 32'(result_o), 32'(0));
        chk("rst_result_count", 32'(result_count_o), 32'(0));
        reset = 1'b0;

        // Directed batches
        push_word(8'd3, 1'b0); push_word(8'd5, 1'b0); push_word(8'd7, 1'b1);
        drain();
        push_word(8'd200, 1'b0); push_word(8'd100, 1'b1);
        drain();
        c0 = n_clear; r0 = n_rv;
        push_word(8'd1, 1'b0); push_word(8'd2, 1'b1); push_word(8'd10, 1'b1);
        drain();
        chk("b2b_clears", 32'(n_clear - c0), 32'(2));
        chk("b2b_results", 32'(n_rv - r0), 32'(2));

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = N'($urandom);
            in_last  = ($urandom_range(0, 2) == 0);
            step();
        end
        in_valid = 1'b0; in_last = 1'b1; in_data = 8'd9;
        push_word(8'd9, 1'b1);
        drain();

        // Push and pop on the same edge with DEPTH-1 entries queued
        lat_fix = 20;
        push_word(8'd11, 1'b0); push_word(8'd12, 1'b0);
        push_word(8'd13, 1'b0); push_word(8'd14, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step();
            if (acc_done) break;
        end
        step();
        in_valid = 1'b1; in_data = 8'd15; in_last = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pp_accept", 32'(accepted), 32'(1));
        chk("pp_load", 32'(load_input_o), 32'(1));
        chk("pp_ready", 32'(in_ready_o), 32'(1));
        drain();
        lat_fix = 0;

        // Watchdog: accumulator never answers
        hang = 1'b1; chk_err = 1'b0;
        push_word(8'd50, 1'b0);
        push_word(8'd21, 1'b0); push_word(8'd22, 1'b0);
        push_word(8'd23, 1'b0); push_word(8'd24, 1'b1);
        chk("full_ready", 32'(in_ready_o), 32'(0));
        in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_reject", 32'(accepted), 32'(0));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (err_o) break;
            step();
        end
        chk("err_raised", 32'(err_o), 32'(1));
        chk("wd_latency", 32'(cyc - last_load_cyc), 32'(TIMEOUT + 1));
        hang = 1'b0; bstart = 1'b1;
        exp_err = 1'b1; chk_err = 1'b1;
        b_sum = 8'd21 + 8'd22 + 8'd23 + 8'd24;
        exp_q.delete();
        exp_q.push_back({8'd4, b_sum});
        c0 = n_clear;
        drain();
        chk("err_new_clear", 32'(n_clear - c0), 32'(1));
        chk("err_sticky", 32'(err_o), 32'(1));

        // Reset while waiting on the accumulator with two words queued
        lat_fix = 40;
        push_word(8'd31, 1'b0); push_word(8'd32, 1'b0); push_word(8'd33, 1'b1);
        repeat (5) step();
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        model_reset();
        reset = 1'b0;
        exp_err = 1'b0;
        chk("mrst_in_ready", 32'(in_ready_o), 32'(1));
        chk("mrst_busy", 32'(busy_o), 32'(0));
        chk("mrst_load", 32'(load_input_o), 32'(0));
        chk("mrst_clear", 32'(clear_acc_o), 32'(0));
        chk("mrst_rv", 32'(result_valid_o), 32'(0));
        chk("mrst_err", 32'(err_o), 32'(0));
        lat_fix = 0;
        repeat (10) step();
        push_word(8'd5, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
